serial_maj_adder: RTL and testbench
===================================

Name: serial_maj_adder

Overview:
- Parametrised, multi-cycle successor to the single-bit majority-carry adder cell.
- Adds or subtracts two WIDTH-bit operands, BPC bits per clock, LSB chunk first.
- Every carry is formed as MAJ(a, b', c); every sum bit is formed as a XOR b' XOR c.
- Sits between a valid/ready producer and a valid/ready consumer in the FCN benchmark datapaths.
- Adds carry-in, subtract mode, signed overflow and backpressure, none of which the single-bit cell has.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 2.
- BPC, 1, bits processed per cycle; must divide WIDTH exactly. Elaboration fails otherwise.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand bundle is valid.
- in_ready  output  1  block can accept a new operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; borrow-in for subtract.
- sub  input  1  0 selects a+b+cin; 1 selects a-b-cin.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  raw carry out of the MSB; for subtract, 1 means no borrow.
- overflow  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

Behaviour:
- States: IDLE, RUN, DONE. N = WIDTH/BPC.
- Reset: on rst=1 at an edge, state becomes IDLE from any state, including mid-RUN and DONE. After reset: in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, chunk counter=0. Any in-flight operation is discarded with no partial output.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On an edge with in_valid=1, the block latches a, b XOR {WIDTH{sub}}, and sub.
  - Initial carry register = cin XOR sub.
  - Counter = 0; next state RUN.
- RUN:
  - in_ready=0 and out_valid=0.
  - Each edge processes chunk k = counter, covering bits [k*BPC +: BPC], through a BPC-deep ripple of majority slices.
  - The chunk's sum bits are written into the result register. The carry register takes the slice chain's carry out. The counter increments.
  - On the edge that processes chunk N-1, the block captures cout and overflow. overflow uses the carry into bit WIDTH-1. The next state is DONE.
- Latency: out_valid rises exactly N edges after the accepting edge (8 edges for the default parameters).
- DONE:
  - out_valid=1 and in_ready=0.
  - sum, cout and overflow are held stable while out_ready=0, for unbounded backpressure.
  - On an edge with out_ready=1, the next state is IDLE. sum, cout and overflow keep their values until the next result is written.
  - A new operation cannot be accepted in the same cycle as the hand-off. Peak throughput is one operation per N+2 cycles.
- Inputs a, b, cin and sub are ignored outside the accepting edge. Changing them during RUN has no effect.
- in_valid may be held high indefinitely; the block accepts only in IDLE.
- Width rules: all arithmetic is unsigned modulo 2^WIDTH. There is no sign extension. overflow is meaningful only for a two's-complement interpretation of the operands.
- No combinational path from any input to any output; in_ready and out_valid are decoded from the state register only.

Decomposition:
- Package maj_adder_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - a function maj3(x, y, z) = (x&y)|(x&z)|(y&z);
  - a constant function for the counter width, clog2(WIDTH/BPC) with a minimum of 1.
- One natural sub-module, maj_fa_slice: a combinational single-bit full adder (inputs a, b, c; outputs s = a^b^c and co = maj3(a,b,c)). It is instantiated BPC times in a generate chain. The carry into the last slice is exposed for overflow.

Test Plan:
- Add, WIDTH=8, BPC=1: a=0x5A, b=0x3C, cin=0, sub=0 -> after 8 edges out_valid=1, sum=0x96, cout=0, overflow=1.
- Add with wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Subtract: a=0x10, b=0x20, cin=0, sub=1 -> sum=0xF0, cout=0, overflow=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, overflow=1.
- Backpressure and handshake:
  - Hold out_ready=0 for 5 cycles after out_valid rises -> sum, cout and overflow stay stable, and in_ready=0 throughout.
  - Toggle a and b during RUN -> the result is unchanged.
  - Raise out_ready -> out_valid falls next cycle and in_ready=1.
- Reset mid-operation: assert rst on the 4th RUN edge -> next cycle in_ready=1, out_valid=0, sum=0. A following op 0x01+0x02 yields 0x03.
- Parameter sweep: WIDTH=8 with BPC in {1, 2, 4, 8} and WIDTH=16 with BPC=4, random operands against a reference model. Latency must equal WIDTH/BPC edges, and results must match in all configurations.

Source files
------------

// File: rtl/maj_adder_pkg.sv
// Shared types and helpers for the bit-serial majority-carry adder.
// Holds the FSM state type, the majority function and the chunk-counter sizing.
package maj_adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Counter width for n chunks; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/maj_fa_slice.sv
// Single-bit full adder whose carry is formed by the majority function.
module maj_fa_slice
  import maj_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = maj3(a, b, c);

endmodule

// File: rtl/serial_maj_adder.sv
// Multi-cycle add/subtract unit: processes BPC bits per clock, LSB chunk first,
// between a valid/ready producer and a valid/ready consumer.
module serial_maj_adder
  import maj_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned N    = (BPC == 0) ? 1 : WIDTH / BPC;
  localparam int unsigned CntW = cnt_width(N);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  if (WIDTH < 2 || BPC == 0 || (WIDTH % BPC) != 0) begin : g_param_check
    $error("serial_maj_adder: WIDTH must be >= 2 and an exact multiple of BPC");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [BPC:0]      carry_chain;
  logic [BPC-1:0]    chunk_s;

  // Operands shift right each RUN edge, so the current chunk is always the low BPC bits.
  assign carry_chain[0] = carry_q;

  for (genvar i = 0; i < BPC; i++) begin : g_slice
    maj_fa_slice u_slice (
      .a  (a_q[i]),
      .b  (b_q[i]),
      .c  (carry_chain[i]),
      .s  (chunk_s[i]),
      .co (carry_chain[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> BPC;
        b_d     = b_q >> BPC;
        // New chunk enters at the top; after N edges the LSB chunk has reached bit 0.
        sum_d   = (sum_q >> BPC) | (WIDTH'(chunk_s) << (WIDTH - BPC));
        carry_d = carry_chain[BPC];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          cout_d  = carry_chain[BPC];
          ovf_d   = carry_chain[BPC-1] ^ carry_chain[BPC];
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_maj_adder.sv
// Self-checking bench for serial_maj_adder: directed vectors plus a per-cycle
// arithmetic model on the default configuration, and a parameter sweep.
module tb_serial_maj_adder;

  int n_tests = 0;
  int n_fail  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Returns {overflow, cout, sum[15:0]} from plain integer arithmetic on w-bit operands.
  function automatic logic [17:0] ref_op(input int w, input logic [15:0] ta, input logic [15:0] tb_,
                                         input logic tc, input logic ts);
    longint m    = (longint'(1) << w) - 1;
    longint half = (m + 1) >> 1;
    longint ua   = longint'(ta) & m;
    longint ub   = longint'(tb_) & m;
    longint c    = longint'(tc);
    longint r, sa, sb, sr;
    logic   co, ov;
    if (!ts) begin
      r  = ua + ub + c;
      co = ((r >> w) & 1) != 0;
    end else begin
      r  = ua - ub - c;
      co = (ua >= ub + c);
    end
    sa = (ua >= half) ? ua - (m + 1) : ua;
    sb = (ub >= half) ? ub - (m + 1) : ub;
    sr = ts ? sa - sb - c : sa + sb + c;
    ov = (sr < -half) || (sr >= half);
    return {ov, co, 16'(r & m)};
  endfunction

  // ---------------- main DUT: WIDTH=8, BPC=1 ----------------
  localparam int MainN = 8;

  logic       rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
  logic [7:0] a, b, sum;
  logic       chk_en = 1'b0;

  serial_maj_adder #(.WIDTH(8), .BPC(1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  // Model: 0 = waiting for an operand, 1 = computing, 2 = result offered.
  int          m_phase = 0;
  int          m_left  = 0;
  logic [17:0] m_pend  = '0;
  logic [7:0]  m_sum   = '0;
  logic        m_cout  = 1'b0;
  logic        m_ovf   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
      m_ovf   <= 1'b0;
    end else if (m_phase == 0) begin
      if (in_valid) begin
        m_pend  <= ref_op(8, 16'(a), 16'(b), cin, sub);
        m_left  <= MainN;
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_phase <= 2;
        m_sum   <= m_pend[7:0];
        m_cout  <= m_pend[16];
        m_ovf   <= m_pend[17];
      end
    end else if (out_ready) begin
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(m_phase == 0));
      check("out_valid", 32'(out_valid), 32'(m_phase == 2));
      if (m_phase != 1) begin
        check("sum", 32'(sum), 32'(m_sum));
        check("cout", 32'(cout), 32'(m_cout));
        check("overflow", 32'(overflow), 32'(m_ovf));
      end
    end
  end

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                       input logic ts, input logic [7:0] es, input logic ec, input logic eo,
                       input int hold);
    int lat;
    @(negedge clk);
    check("op_in_ready", 32'(in_ready), 32'd1);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 64) begin
      a = ~a; b = b ^ 8'h5a; cin = ~cin; sub = ~sub;
      @(negedge clk);
      lat++;
    end
    check("op_latency", 32'(lat), 32'(MainN));
    check("op_sum", 32'(sum), 32'(es));
    check("op_cout", 32'(cout), 32'(ec));
    check("op_ovf", 32'(overflow), 32'(eo));
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_sum", 32'(sum), 32'(es));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("handoff_valid", 32'(out_valid), 32'd0);
    check("handoff_in_ready", 32'(in_ready), 32'd1);
    check("handoff_sum", 32'(sum), 32'(es));
  endtask

  // ---------------- parameter sweep ----------------
  logic sw_rst;

  for (genvar g = 0; g < 5; g++) begin : g_sweep
    localparam int unsigned W = (g == 4) ? 16 : 8;
    localparam int unsigned B = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 8 : 4;

    logic         s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_out_ready;
    logic         s_cout, s_ovf;
    logic [W-1:0] s_a, s_b, s_sum;
    bit           done_f = 1'b0;

    serial_maj_adder #(.WIDTH(W), .BPC(B)) u_sw (
      .clk       (clk),
      .rst       (sw_rst),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .a         (s_a),
      .b         (s_b),
      .cin       (s_cin),
      .sub       (s_sub),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .sum       (s_sum),
      .cout      (s_cout),
      .overflow  (s_ovf)
    );

    initial begin
      int          lat;
      logic [17:0] e;
      logic [15:0] ra, rb;
      logic        rc, rs;
      s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
      @(negedge clk);
      while (sw_rst) @(negedge clk);
      for (int k = 0; k < 12; k++) begin
        ra = 16'($urandom); rb = 16'($urandom);
        rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
        if (k == 0) begin ra = 16'hffff; rb = 16'h0001; rc = 1'b0; rs = 1'b0; end
        check($sformatf("sw%0d_in_ready", g), 32'(s_in_ready), 32'd1);
        s_a = ra[W-1:0]; s_b = rb[W-1:0]; s_cin = rc; s_sub = rs; s_in_valid = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 64) begin
          @(negedge clk);
          lat++;
        end
        e = ref_op(int'(W), ra, rb, rc, rs);
        check($sformatf("sw%0d_latency", g), 32'(lat), 32'(W / B));
        check($sformatf("sw%0d_sum", g), 32'(s_sum), 32'(e[W-1:0]));
        check($sformatf("sw%0d_cout", g), 32'(s_cout), 32'(e[16]));
        check($sformatf("sw%0d_ovf", g), 32'(s_ovf), 32'(e[17]));
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
      end
      done_f = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int  waited;
    logic all_done;
    rst = 1'b1; sw_rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; sw_rst = 1'b0;
    chk_en = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    do_op(8'h5a, 8'h3c, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 5);
    do_op(8'hff, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    do_op(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'h10, 8'h20, 1'b0, 1'b1, 8'hf0, 1'b0, 1'b0, 2);
    do_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7f, 1'b1, 1'b1, 0);

    // Reset on the 4th RUN edge discards the operation.
    @(negedge clk);
    a = 8'h5a; b = 8'h3c; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    do_op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 0);

    // Free-running traffic with random handshakes; the per-cycle model does the checking.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) == 0);
      a = 8'($urandom); b = 8'($urandom);
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(negedge clk);
    out_ready = 1'b0;

    waited = 0;
    all_done = 1'b0;
    while (!all_done && waited < 20000) begin
      all_done = g_sweep[0].done_f && g_sweep[1].done_f && g_sweep[2].done_f &&
                 g_sweep[3].done_f && g_sweep[4].done_f;
      @(negedge clk);
      waited++;
    end
    check("sweep_complete", 32'(all_done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
